hour_bcd_setter: RTL and testbench

//  Inverse of the hour display path: takes a user-entered hour as two BCD digits (tens, then units) over a valid/ready handshake.

---
 rtl/watch_pkg.sv | 17 +
 rtl/bcd2bin_2digit.sv | 24 ++
 rtl/hour_bcd_setter.sv | 131 +++++++++++++
 tb/tb_hour_bcd_setter.sv | 180 ++++++++++++++++++
 4 files changed

// File: rtl/watch_pkg.sv
// Shared watch definitions: FSM state encoding and hours-per-day constants.
// Latency: n/a (package only).
// Backpressure: n/a.
package watch_pkg;

    // Entry/run state encoding, shared by the hour and minute setters
    typedef enum logic [1:0] {
        S_TENS  = 2'd0,
        S_UNITS = 2'd1,
        S_RUN   = 2'd2
    } state_t;

    // Hours-per-day choices, shared with the display counter
    localparam int HOURS_24 = 24;
    localparam int HOURS_12 = 12;

endpackage

// File: rtl/bcd2bin_2digit.sv
// Two BCD digits (tens, units) to binary, plus a flag for an out-of-range units digit.
// Latency: purely combinational.
// Backpressure: none; no state.
module bcd2bin_2digit #(
    parameter int W = 5
) (
    input  logic [3:0] i_tens,
    input  logic [3:0] i_units,
    output logic [W:0] o_bin,
    output logic       o_units_bad
);

    logic [W:0] w_t;
    logic [W:0] w_u;

    // Zero-extend both digits to the result width before shifting
    assign w_t = {{(W-3){1'b0}}, i_tens};
    assign w_u = {{(W-3){1'b0}}, i_units};

    // tens*10 as (t<<3)+(t<<1), evaluated at W+1 bits
    assign o_bin       = (w_t << 3) + (w_t << 1) + w_u;
    assign o_units_bad = (i_units > 4'd9);

endmodule

// File: rtl/hour_bcd_setter.sv
// Accepts an hour as two BCD digits, range-checks it, loads it and then counts hours.
// Latency: hour_o/hour_valid_o update on the edge that accepts the units digit; err_o/day_tick_o are registered pulses.
// Backpressure: digit_ready_o is high only while awaiting a digit and set_i is low.
module hour_bcd_setter
    import watch_pkg::*;
#(
    parameter int HOURS = 24,
    parameter int W     = 5
) (
    input  logic         clk60m_i,
    input  logic         rstn_i,
    input  logic         set_i,
    input  logic [3:0]   digit_i,
    input  logic         digit_valid_i,
    output logic         digit_ready_o,
    output logic [W-1:0] hour_o,
    output logic         hour_valid_o,
    output logic         err_o,
    output logic         day_tick_o
);

    localparam logic [3:0]   TENS_MAX = 4'((HOURS - 1) / 10);
    localparam logic [W:0]   HOURS_V  = (W+1)'(HOURS);
    localparam logic [W-1:0] HOUR_MAX = W'(HOURS - 1);

    state_t       r_state;
    logic [3:0]   r_tens;
    logic [W-1:0] r_hour;
    logic         r_hour_vld;
    logic         r_err;
    logic         r_tick;

    state_t       w_state_nxt;
    logic [3:0]   w_tens_nxt;
    logic [W-1:0] w_hour_nxt;
    logic         w_hour_vld_nxt;
    logic         w_err_nxt;
    logic         w_tick_nxt;

    logic         w_xfer;
    logic [W:0]   w_bin;
    logic         w_units_bad;

    bcd2bin_2digit #(.W(W)) u_bcd2bin (
        .i_tens      (r_tens),
        .i_units     (digit_i),
        .o_bin       (w_bin),
        .o_units_bad (w_units_bad)
    );

    // set_i masks ready so a digit offered alongside it is never taken
    assign digit_ready_o = ((r_state == S_TENS) || (r_state == S_UNITS)) && !set_i;
    assign w_xfer        = digit_valid_i && digit_ready_o;

    // Next-state and next-output decode; set_i overrides everything
    always_comb begin
        w_state_nxt    = r_state;
        w_tens_nxt     = r_tens;
        w_hour_nxt     = r_hour;
        w_hour_vld_nxt = r_hour_vld;
        w_err_nxt      = 1'b0;
        w_tick_nxt     = 1'b0;
        if (set_i) begin
            w_state_nxt    = S_TENS;
            w_hour_vld_nxt = 1'b0;
        end else begin
            case (r_state)
                S_TENS: begin
                    if (w_xfer) begin
                        if (digit_i > TENS_MAX) begin
                            w_err_nxt = 1'b1;
                        end else begin
                            w_tens_nxt  = digit_i;
                            w_state_nxt = S_UNITS;
                        end
                    end
                end
                S_UNITS: begin
                    if (w_xfer) begin
                        if (w_units_bad || (w_bin >= HOURS_V)) begin
                            w_err_nxt   = 1'b1;
                            w_tens_nxt  = 4'd0;
                            w_state_nxt = S_TENS;
                        end else begin
                            // Load edge only; counting starts on the following edge
                            w_hour_nxt     = w_bin[W-1:0];
                            w_hour_vld_nxt = 1'b1;
                            w_state_nxt    = S_RUN;
                        end
                    end
                end
                S_RUN: begin
                    if (r_hour == HOUR_MAX) begin
                        w_hour_nxt = '0;
                        w_tick_nxt = 1'b1;
                    end else begin
                        w_hour_nxt = r_hour + 1'b1;
                    end
                end
                default: begin
                    w_state_nxt = S_TENS;
                end
            endcase
        end
    end

    // State and output registers, cleared immediately by reset
    always_ff @(posedge clk60m_i or negedge rstn_i) begin
        if (!rstn_i) begin
            r_state    <= S_TENS;
            r_tens     <= 4'd0;
            r_hour     <= '0;
            r_hour_vld <= 1'b0;
            r_err      <= 1'b0;
            r_tick     <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_tens     <= w_tens_nxt;
            r_hour     <= w_hour_nxt;
            r_hour_vld <= w_hour_vld_nxt;
            r_err      <= w_err_nxt;
            r_tick     <= w_tick_nxt;
        end
    end

    assign hour_o       = r_hour;
    assign hour_valid_o = r_hour_vld;
    assign err_o        = r_err;
    assign day_tick_o   = r_tick;

endmodule

// File: tb/tb_hour_bcd_setter.sv
// Directed bench for hour_bcd_setter: a 24 h instance and a 12 h instance.
// Latency: checks sampled 1 time unit after each rising edge.
// Backpressure: digit_ready_o checked directly against the entry state.
module tb_hour_bcd_setter;

    logic       clk60m_i = 1'b0;
    always #5 clk60m_i = ~clk60m_i;

    // 24 h instance
    logic       a_rstn, a_set, a_vld, a_rdy, a_hv, a_err, a_tick;
    logic [3:0] a_dig;
    logic [4:0] a_hour;

    // 12 h instance
    logic       b_rstn, b_set, b_vld, b_rdy, b_hv, b_err, b_tick;
    logic [3:0] b_dig;
    logic [3:0] b_hour;

    int checks = 0;
    int errors = 0;

    hour_bcd_setter #(.HOURS(24), .W(5)) u_dut_a (
        .clk60m_i      (clk60m_i),
        .rstn_i        (a_rstn),
        .set_i         (a_set),
        .digit_i       (a_dig),
        .digit_valid_i (a_vld),
        .digit_ready_o (a_rdy),
        .hour_o        (a_hour),
        .hour_valid_o  (a_hv),
        .err_o         (a_err),
        .day_tick_o    (a_tick)
    );

    hour_bcd_setter #(.HOURS(12), .W(4)) u_dut_b (
        .clk60m_i      (clk60m_i),
        .rstn_i        (b_rstn),
        .set_i         (b_set),
        .digit_i       (b_dig),
        .digit_valid_i (b_vld),
        .digit_ready_o (b_rdy),
        .hour_o        (b_hour),
        .hour_valid_o  (b_hv),
        .err_o         (b_err),
        .day_tick_o    (b_tick)
    );

    task automatic chk(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk60m_i);
        #1;
    endtask

    initial begin
        a_rstn = 1'b0; a_set = 1'b0; a_vld = 1'b0; a_dig = 4'd0;
        b_rstn = 1'b0; b_set = 1'b0; b_vld = 1'b0; b_dig = 4'd0;
        #12;
        chk("rst_hour", a_hour, 0);
        chk("rst_hv", a_hv, 0);
        chk("rst_err", a_err, 0);
        chk("rst_tick", a_tick, 0);
        chk("rst_rdy", a_rdy, 1);
        step();
        a_rstn = 1'b1; b_rstn = 1'b1;
        step();

        // 1: digits 1,7 with valid held
        a_vld = 1'b1; a_dig = 4'd1; #1;
        chk("t1_rdy_tens", a_rdy, 1);
        step();
        chk("t1_hv_mid", a_hv, 0);
        a_dig = 4'd7; #1;
        chk("t1_rdy_units", a_rdy, 1);
        step();
        a_vld = 1'b0;
        chk("t1_hour17", a_hour, 17);
        chk("t1_hv", a_hv, 1);
        chk("t1_rdy_run", a_rdy, 0);
        step();
        chk("t1_hour18", a_hour, 18);

        // 2: load 23, wrap to 0 with a single day tick
        a_set = 1'b1; step(); a_set = 1'b0;
        chk("t2_set_hv", a_hv, 0);
        chk("t2_set_hold", a_hour, 18);
        a_vld = 1'b1; a_dig = 4'd2; step();
        a_dig = 4'd3; step(); a_vld = 1'b0;
        chk("t2_hour23", a_hour, 23);
        chk("t2_tick_pre", a_tick, 0);
        step();
        chk("t2_wrap", a_hour, 0);
        chk("t2_tick", a_tick, 1);
        step();
        chk("t2_hour1", a_hour, 1);
        chk("t2_tick_off", a_tick, 0);

        // 3: tens 3 rejected; then 2,4 rejected on units
        a_set = 1'b1; step(); a_set = 1'b0;
        chk("t3_frozen", a_hour, 1);
        a_vld = 1'b1; a_dig = 4'd3; step();
        chk("t3_err_tens", a_err, 1);
        a_dig = 4'd2; step();
        chk("t3_err_clr", a_err, 0);
        a_dig = 4'd4; step();
        chk("t3_err_units", a_err, 1);
        chk("t3_hv", a_hv, 0);
        chk("t3_hold", a_hour, 1);

        // 4: units 0xA rejected; then 0,9 loads 9
        a_dig = 4'd0; step();
        chk("t4_err_clr", a_err, 0);
        a_dig = 4'hA; step();
        chk("t4_err_a", a_err, 1);
        a_dig = 4'd0; step();
        a_dig = 4'd9; step(); a_vld = 1'b0;
        chk("t4_hour9", a_hour, 9);
        chk("t4_hv", a_hv, 1);
        chk("t4_err_off", a_err, 0);

        // 5: set with simultaneous digit while running at 5
        a_set = 1'b1; step(); a_set = 1'b0;
        a_vld = 1'b1; a_dig = 4'd0; step();
        a_dig = 4'd5; step();
        chk("t5_hour5", a_hour, 5);
        a_set = 1'b1; a_dig = 4'd1; #1;
        chk("t5_rdy_set", a_rdy, 0);
        step();
        chk("t5_hv", a_hv, 0);
        chk("t5_hold5", a_hour, 5);
        chk("t5_no_err", a_err, 0);
        chk("t5_no_tick", a_tick, 0);
        a_set = 1'b0; a_dig = 4'd1; step();
        a_dig = 4'd2; step(); a_vld = 1'b0;
        chk("t5_hour12", a_hour, 12);
        chk("t5_hv12", a_hv, 1);

        // 6: 12 h instance
        b_vld = 1'b1; b_dig = 4'd2; step();
        chk("b_err_tens2", b_err, 1);
        b_dig = 4'd1; step();
        b_dig = 4'd2; step();
        chk("b_err_12", b_err, 1);
        chk("b_hv_12", b_hv, 0);
        b_dig = 4'd1; step();
        b_dig = 4'd1; step(); b_vld = 1'b0;
        chk("b_hour11", b_hour, 11);
        chk("b_hv11", b_hv, 1);
        step();
        chk("b_wrap", b_hour, 0);
        chk("b_tick", b_tick, 1);
        step();
        chk("b_hour1", b_hour, 1);
        b_set = 1'b1; step(); b_set = 1'b0;
        b_vld = 1'b1; b_dig = 4'd1; step(); b_vld = 1'b0;
        chk("b_units_hold", b_hour, 1);
        #2 b_rstn = 1'b0; #1;
        chk("b_rst_hour", b_hour, 0);
        chk("b_rst_hv", b_hv, 0);
        chk("b_rst_err", b_err, 0);
        chk("b_rst_tick", b_tick, 0);
        chk("b_rst_rdy", b_rdy, 1);
        step();
        b_rstn = 1'b1;
        step();
        b_vld = 1'b1; b_dig = 4'd0; step();
        b_dig = 4'd7; step(); b_vld = 1'b0;
        chk("b_after_rst", b_hour, 7);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
